irq_request_capture: RTL and testbench
======================================

// Module: irq_request_capture
// PURPOSE
//  Parametrised interrupt-request capture stage of the PIC: synchronises NUM_IRQ async request pins,
//  applies per-channel trigger mode (level / rising / falling / both edges), queues edge events in a
//  per-channel saturating counter, and presents the IRR to the priority resolver and ISR logic.
//  Control-unit acks (clear_irr) consume one queued event; freeze holds the visible IRR during INTA.
// PARAMETERS
//  NUM_IRQ      8  number of request channels (1..32)
//  SYNC_STAGES  2  synchroniser flops per pin (1..4)
//  CNT_W        2  width of per-channel pending-edge counter (1..4); max queued = 2**CNT_W-1
// PORTS
//  clk        in   1            clock
//  rst        in   1            reset, asynchronous, active-low
//  irq_pin    in   NUM_IRQ      raw request pins from I/O devices (asynchronous)
//  trig_mode  in   2*NUM_IRQ    per channel {b1,b0} at [2i+1:2i]: 00 level-high, 01 rising, 10 falling, 11 both
//  freeze     in   1            hold irr outputs (events still queued)
//  clear_irr  in   NUM_IRQ      per-channel ack from control unit (one-cycle pulse)
//  ovf_clear  in   NUM_IRQ      per-channel clear of sticky overflow
//  irr        out  NUM_IRQ      interrupt request register (registered)
//  pend_cnt   out  CNT_W*NUM_IRQ per-channel queued-edge count, channel i at [CNT_W*i +: CNT_W]
//  overflow   out  NUM_IRQ      sticky: edge event arrived while counter saturated
// BEHAVIOUR
//  - Reset (rst=0, async): sync chains, s_d, irr, pend_cnt, overflow, warm-up counter -> 0; armed -> 0.
//  - Sync: s[i] = last stage of SYNC_STAGES-flop chain; s_d[i] = s[i] delayed one clk (always updated).
//  - Warm-up: counter runs SYNC_STAGES+1 cycles after reset release, then sets armed=1 (stays 1).
//    While armed=0 no edge events are generated and irr stays 0 (no spurious edge from reset values).
//  - Event (edge modes, armed): rise = s & ~s_d, fall = ~s & s_d; ev = rise (01), fall (10), rise|fall (11).
//  - Edge-mode counter per cycle: ev & ~clear -> cnt+1 (saturate at max; if already max set overflow);
//    clear & ~ev -> cnt-1 (no underflow: cnt=0 stays 0); ev & clear -> cnt unchanged; else hold.
//  - Level mode (00): cnt forced 0, overflow never set; level value = s[i].
//  - Next-irr value n[i] = (mode==00) ? s[i] : (cnt_next != 0).
//  - irr[i] update priority: clear_irr[i] & mode==00 -> 0; else freeze -> hold (edge-mode clear still
//    decrements cnt); else irr <= n[i]. In edge mode with freeze=0, irr <= (cnt_next != 0).
//  - Latency pin -> irr: SYNC_STAGES+1 cycles in all modes; ack -> irr low: 1 cycle if cnt becomes 0.
//  - freeze deassert: irr takes n[i] on the first clk with freeze=0; events queued during freeze not lost.
//  - trig_mode[i] change (sampled vs. registered copy): that cycle cnt[i] <- 0, no event, irr[i] <- 0
//    (unless freeze holds it); overflow unaffected. Registered mode copy resets to 00.
//  - overflow[i]: set on saturating event, cleared by ovf_clear[i]; set wins when both same cycle.
//  - Reset mid-operation: everything returns to reset values immediately; warm-up restarts on release.
// STRUCTURE
//  - Shared package pic_pkg: localparams TRIG_LEVEL=2'b00, TRIG_RISE=2'b01, TRIG_FALL=2'b10,
//    TRIG_BOTH=2'b11; shared with ICW/OCW decode in control logic.
//  - Sub-module irq_channel (one instance per channel via generate): sync chain, s_d, mode register,
//    counter, irr and overflow flops. Top holds the warm-up counter/armed flag and port slicing.
// TESTING
//  1 Reset: hold rst=0 with irq_pin=8'hFF, modes all 01; release -> irr=0, pend_cnt=0 through warm-up,
//    no events while pins stay high.
//  2 Level: ch0 mode 00, pin0 0->1 -> irr[0]=1 after 3 clks (SYNC_STAGES=2); clear_irr[0] pulse -> irr[0]=0
//    one cycle, re-asserts next cycle while pin high.
//  3 Edge queue: ch3 mode 01, three rising pulses -> pend_cnt[3]=3, irr[3]=1; fourth pulse -> cnt stays 3,
//    overflow[3]=1; three acks -> cnt 2,1,0 and irr[3]=0 after third.
//  4 Simultaneous: ch5 mode 11, cnt=1, edge event and clear_irr[5] same cycle -> cnt stays 1, irr[5] stays 1.
//  5 Freeze: freeze=1, ch2 mode 10 falling edge -> irr[2] held 0, pend_cnt[2]=1; freeze=0 -> irr[2]=1 next clk.
//  6 Mode change + mid-op reset: ch1 cnt=2, switch mode 01->11 -> cnt 0, irr[1]=0; then assert rst mid-burst
//    -> all outputs 0 asynchronously, overflow cleared.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared PIC definitions: trigger-mode encodings used by request capture and ICW/OCW decode.
package pic_pkg;

  typedef enum logic [1:0] {
    TRIG_LEVEL = 2'b00,
    TRIG_RISE  = 2'b01,
    TRIG_FALL  = 2'b10,
    TRIG_BOTH  = 2'b11
  } trig_mode_e;

endpackage

// File: rtl/irq_request_capture_channel.sv
// One request channel: pin synchroniser, trigger-mode edge detect, pending-edge queue,
// IRR bit and sticky overflow flag.
module irq_channel
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic [1:0]       mode,
  input  logic             armed,
  input  logic             freeze,
  input  logic             clear,
  input  logic             ovf_clear,
  output logic             irr,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d;
  trig_mode_e             mode_i, mode_q;
  logic                   mode_chg, rise, fall, ev, ovf_set, lvl_val;
  logic [CNT_W-1:0]       cnt_next;
  logic                   irr_next;

  assign s      = sync[SYNC_STAGES-1];
  assign mode_i = trig_mode_e'(mode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      s_d    <= 1'b0;
      mode_q <= TRIG_LEVEL;
    end else begin
      sync[0] <= pin;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      s_d    <= s;
      mode_q <= mode_i;
    end
  end

  always_comb begin
    rise     = s & ~s_d;
    fall     = ~s & s_d;
    mode_chg = (mode_i != mode_q);
    ev       = 1'b0;
    if (armed && !mode_chg) begin
      case (mode_i)
        TRIG_RISE: ev = rise;
        TRIG_FALL: ev = fall;
        TRIG_BOTH: ev = rise | fall;
        default:   ev = 1'b0;
      endcase
    end

    cnt_next = cnt;
    ovf_set  = 1'b0;
    if (mode_chg || mode_i == TRIG_LEVEL) begin
      cnt_next = '0;
    end else if (ev && !clear) begin
      if (cnt == CNT_MAX) ovf_set = 1'b1;
      else                cnt_next = cnt + CNT_W'(1);
    end else if (clear && !ev && cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end

    // Level-mode ack beats freeze; a mode change only drops irr when not frozen.
    lvl_val  = (mode_i == TRIG_LEVEL) ? s : (cnt_next != '0);
    irr_next = irr;
    if (mode_i == TRIG_LEVEL && clear) irr_next = 1'b0;
    else if (!freeze)                  irr_next = (armed && !mode_chg) ? lvl_val : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      irr      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      irr      <= irr_next;
      overflow <= ovf_set | (overflow & ~ovf_clear);
    end
  end

endmodule

// File: rtl/irq_request_capture.sv
// PIC interrupt-request capture: per-channel capture instances plus the post-reset warm-up
// that suppresses spurious edges while the synchronisers fill.
module irq_request_capture
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IRQ-1:0]       irq_pin,
  input  logic [2*NUM_IRQ-1:0]     trig_mode,
  input  logic                     freeze,
  input  logic [NUM_IRQ-1:0]       clear_irr,
  input  logic [NUM_IRQ-1:0]       ovf_clear,
  output logic [NUM_IRQ-1:0]       irr,
  output logic [CNT_W*NUM_IRQ-1:0] pend_cnt,
  output logic [NUM_IRQ-1:0]       overflow
);

  localparam int unsigned WU_W = $clog2(SYNC_STAGES + 1) + 1;

  logic [WU_W-1:0] wu_cnt;
  logic            armed;

  // armed rises on the (SYNC_STAGES+1)th clock after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu_cnt <= '0;
      armed  <= 1'b0;
    end else if (!armed) begin
      if (wu_cnt == WU_W'(SYNC_STAGES)) armed  <= 1'b1;
      else                              wu_cnt <= wu_cnt + WU_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    irq_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pin      (irq_pin[i]),
      .mode     (trig_mode[2*i +: 2]),
      .armed    (armed),
      .freeze   (freeze),
      .clear    (clear_irr[i]),
      .ovf_clear(ovf_clear[i]),
      .irr      (irr[i]),
      .cnt      (pend_cnt[CNT_W*i +: CNT_W]),
      .overflow (overflow[i])
    );
  end

endmodule

// File: tb/tb_irq_request_capture.sv
// Self-checking bench for irq_request_capture: directed scenarios plus randomized traffic
// against a delay-line / integer-counter reference model.
module tb_irq_request_capture;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    irq_pin;
  logic [2*N-1:0]  trig_mode;
  logic            freeze;
  logic [N-1:0]    clear_irr;
  logic [N-1:0]    ovf_clear;
  logic [N-1:0]    irr;
  logic [CW*N-1:0] pend_cnt;
  logic [N-1:0]    overflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] hist [N];   // bit k = pin sampled k+1 clocks ago
  logic [1:0] pm   [N];
  int         cnt_m[N];
  bit         irr_m[N];
  bit         ovf_m[N];
  int         warm;

  irq_request_capture #(
    .NUM_IRQ    (N),
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_pin  (irq_pin),
    .trig_mode(trig_mode),
    .freeze   (freeze),
    .clear_irr(clear_irr),
    .ovf_clear(ovf_clear),
    .irr      (irr),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i] = '0; pm[i] = 2'b00; cnt_m[i] = 0; irr_m[i] = 0; ovf_m[i] = 0;
    end
    warm = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic [1:0] md;
      bit s, sd, chg, lvl, arm, ev, c, oset;
      int nc;
      md   = trig_mode[2*i +: 2];
      s    = hist[i][SYNC-1];
      sd   = hist[i][SYNC];
      chg  = (md != pm[i]);
      lvl  = (md == 2'b00);
      arm  = (warm >= SYNC + 1);
      c    = clear_irr[i];
      ev   = arm && !chg && ((md == 2'b01 && s && !sd) || (md == 2'b10 && !s && sd) ||
                             (md == 2'b11 && s != sd));
      oset = 0;
      nc   = cnt_m[i];
      if (chg || lvl) nc = 0;
      else if (ev && !c) begin
        if (cnt_m[i] == MAXC) oset = 1;
        nc = (cnt_m[i] + 1 > MAXC) ? MAXC : cnt_m[i] + 1;
      end else if (c && !ev) nc = (cnt_m[i] > 0) ? cnt_m[i] - 1 : 0;

      if (lvl && c)  irr_m[i] = 0;
      else if (freeze) irr_m[i] = irr_m[i];
      else if (chg || !arm) irr_m[i] = 0;
      else irr_m[i] = lvl ? s : (nc != 0);

      ovf_m[i] = oset || (ovf_m[i] && !ovf_clear[i]);
      cnt_m[i] = nc;
      hist[i]  = {hist[i][6:0], irq_pin[i]};
      pm[i]    = md;
    end
    if (warm < 100) warm++;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
    end
  endtask

  function automatic logic [N-1:0] exp_irr();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = irr_m[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ovf_m[i];
    return v;
  endfunction

  function automatic logic [CW*N-1:0] exp_pend();
    logic [CW*N-1:0] v;
    for (int i = 0; i < N; i++) v[CW*i +: CW] = CW'(cnt_m[i]);
    return v;
  endfunction

  task automatic pulse(input int ch);
    irq_pin[ch] = 1'b0; tick(2);
    irq_pin[ch] = 1'b1; tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_pin = '1; trig_mode = {N{2'b01}}; freeze = 0; clear_irr = '0; ovf_clear = '0;
    model_reset();
    #12;
    total++;
    if (irr !== '0 || pend_cnt !== '0 || overflow !== '0) begin
      bad++; $display("FAIL reset_hold irr=%h pend=%h ovf=%h required all 0", irr, pend_cnt, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (irr !== '0 || pend_cnt !== '0 || irr !== exp_irr()) begin
        bad++; $display("FAIL warmup cyc=%0d irr=%h pend=%h required 0", k, irr, pend_cnt);
      end
    end
  endtask

  task automatic test_level();
    trig_mode = 16'h5554; irq_pin = 8'hFE; tick(4);
    irq_pin[0] = 1'b1; tick(2);
    total++;
    if (irr[0] !== 1'b0) begin bad++; $display("FAIL level_early irr0=%b required 0", irr[0]); end
    tick();
    total++;
    if (irr[0] !== 1'b1 || irr !== exp_irr()) begin
      bad++; $display("FAIL level_latency irr=%h required %h (bit0=1)", irr, exp_irr());
    end
    clear_irr[0] = 1'b1; tick(); clear_irr[0] = 1'b0;
    total++;
    if (irr[0] !== 1'b0) begin bad++; $display("FAIL level_ack irr0=%b required 0", irr[0]); end
    tick();
    total++;
    if (irr[0] !== 1'b1) begin bad++; $display("FAIL level_reassert irr0=%b required 1", irr[0]); end
  endtask

  task automatic test_edge_queue();
    for (int p = 0; p < 3; p++) pulse(3);
    tick(2);
    total++;
    if (pend_cnt[6 +: 2] !== 2'd3 || irr[3] !== 1'b1 || pend_cnt !== exp_pend()) begin
      bad++; $display("FAIL queue3 cnt3=%0d irr3=%b required 3/1", pend_cnt[6 +: 2], irr[3]);
    end
    pulse(3); tick(2);
    total++;
    if (pend_cnt[6 +: 2] !== 2'd3 || overflow[3] !== 1'b1) begin
      bad++; $display("FAIL saturate cnt3=%0d ovf3=%b required 3/1", pend_cnt[6 +: 2], overflow[3]);
    end
    for (int a = 2; a >= 0; a--) begin
      clear_irr[3] = 1'b1; tick(); clear_irr[3] = 1'b0;
      total++;
      if (pend_cnt[6 +: 2] !== 2'(a) || irr[3] !== (a != 0)) begin
        bad++; $display("FAIL ack_drain cnt3=%0d irr3=%b required %0d/%0b",
                        pend_cnt[6 +: 2], irr[3], a, a != 0);
      end
    end
  endtask

  task automatic test_simultaneous();
    trig_mode[11:10] = 2'b11; tick();
    irq_pin[5] = 1'b0; tick(4);
    total++;
    if (pend_cnt[10 +: 2] !== 2'd1) begin
      bad++; $display("FAIL both_fall cnt5=%0d required 1", pend_cnt[10 +: 2]);
    end
    irq_pin[5] = 1'b1; tick(2);
    clear_irr[5] = 1'b1; tick(); clear_irr[5] = 1'b0;
    total++;
    if (pend_cnt[10 +: 2] !== 2'd1 || irr[5] !== 1'b1 || pend_cnt !== exp_pend()) begin
      bad++; $display("FAIL ev_and_clear cnt5=%0d irr5=%b required 1/1", pend_cnt[10 +: 2], irr[5]);
    end
  endtask

  task automatic test_freeze();
    trig_mode[5:4] = 2'b10; tick(2);
    freeze = 1'b1; irq_pin[2] = 1'b0; tick(4);
    total++;
    if (irr[2] !== 1'b0 || pend_cnt[4 +: 2] !== 2'd1) begin
      bad++; $display("FAIL freeze_hold irr2=%b cnt2=%0d required 0/1", irr[2], pend_cnt[4 +: 2]);
    end
    freeze = 1'b0; tick();
    total++;
    if (irr[2] !== 1'b1 || irr !== exp_irr()) begin
      bad++; $display("FAIL freeze_release irr=%h required %h (bit2=1)", irr, exp_irr());
    end
  endtask

  task automatic test_mode_change_reset();
    pulse(1); pulse(1); tick(2);
    total++;
    if (pend_cnt[2 +: 2] !== 2'd2) begin
      bad++; $display("FAIL pre_modechg cnt1=%0d required 2", pend_cnt[2 +: 2]);
    end
    trig_mode[3:2] = 2'b11; tick();
    total++;
    if (pend_cnt[2 +: 2] !== 2'd0 || irr[1] !== 1'b0 || overflow !== exp_ovf()) begin
      bad++; $display("FAIL modechg cnt1=%0d irr1=%b required 0/0", pend_cnt[2 +: 2], irr[1]);
    end
    for (int k = 0; k < 3; k++) begin irq_pin[1] = ~irq_pin[1]; tick(); end
    #3 rst = 1'b0; model_reset();
    #1;
    total++;
    if (irr !== '0 || pend_cnt !== '0 || overflow !== '0) begin
      bad++; $display("FAIL async_reset irr=%h pend=%h ovf=%h required all 0", irr, pend_cnt, overflow);
    end
    tick(2);
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k % 64 == 0) trig_mode = 16'($urandom);
      irq_pin   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_pin;
      clear_irr = 8'($urandom & $urandom & $urandom);
      ovf_clear = 8'($urandom & $urandom & $urandom);
      freeze    = ($urandom_range(0, 9) == 0);
      tick();
      total++;
      if (irr !== exp_irr() || pend_cnt !== exp_pend() || overflow !== exp_ovf()) begin
        bad++;
        $display("FAIL random cyc=%0d irr=%h/%h pend=%h/%h ovf=%h/%h (actual/required)",
                 k, irr, exp_irr(), pend_cnt, exp_pend(), overflow, exp_ovf());
      end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_queue();
    test_simultaneous();
    test_freeze();
    test_mode_change_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
